hpdcache_victim_sel: RTL and testbench
======================================

// Module: hpdcache_victim_sel
// PURPOSE
//  Victim-way selector for the HPDcache random replacement policy, directly downstream of
//  the pseudo-random LFSR. On a miss refill it returns one way (one-hot) to evict: first free
//  invalid way, else a pseudo-random start way taken from the LFSR, skipping ways locked by
//  in-flight refills. Pulses the LFSR shift request whenever a random value is consumed.
// PARAMETERS
//  WAYS        8  number of cache ways; power of two, 2..32
//  LFSR_WIDTH  8  width of lfsr_val_i; must be >= $clog2(WAYS)
// PORTS
//  clk_i           in   1           clock
//  rst_ni          in   1           reset, asynchronous, active-low
//  req_valid_i     in   1           selection request
//  req_ready_o     out  1           selector idle, can accept request
//  req_valid_ways_i in  WAYS        per-way valid bits of target set
//  req_busy_ways_i in   WAYS        per-way lock (refill pending); locked ways never chosen
//  lfsr_val_i      in   LFSR_WIDTH  current LFSR value
//  lfsr_shift_o    out  1           one-cycle pulse: advance LFSR
//  rsp_valid_o     out  1           response valid
//  rsp_ready_i     in   1           consumer accepts response
//  rsp_way_o       out  WAYS        one-hot victim way (all-zero when rsp_none_o)
//  rsp_none_o      out  1           every way locked, no victim
// BEHAVIOUR
//  - Reset: state IDLE; rsp_valid_o=0, rsp_way_o=0, rsp_none_o=0, lfsr_shift_o=0,
//    req_ready_o=1 once rst_ni deasserts (req_ready_o decoded from state IDLE only).
//  - States IDLE, SCAN, RESP. Request accepted when req_valid_i && req_ready_o (cycle T);
//    valid/busy vectors registered at T; inputs ignored after T until back in IDLE.
//  - IDLE, accept, free = ~valid & ~busy non-zero: victim = lowest-index set bit of free;
//    -> RESP; rsp_valid_o at T+1. lfsr_shift_o stays 0 (random value not consumed).
//  - IDLE, accept, free == 0: start = lfsr_val_i[$clog2(WAYS)-1:0]; lfsr_shift_o=1 in cycle T.
//    If busy[start]==0: victim=start, -> RESP (rsp_valid_o at T+1).
//    Else -> SCAN with idx=(start+1) mod WAYS, cnt=1.
//  - SCAN: one way examined per cycle. busy[idx]==0: victim=idx, -> RESP next cycle.
//    Else idx wraps modulo WAYS, cnt++; if cnt reaches WAYS with no free way: rsp_none_o=1,
//    rsp_way_o=0, -> RESP. Worst-case latency accept->rsp_valid_o = WAYS cycles.
//  - RESP: rsp_valid_o=1; rsp_way_o/rsp_none_o stable until rsp_ready_i; on handshake
//    -> IDLE (rsp_valid_o=0 next cycle); new request acceptable the cycle after handshake.
//    No request/response overlap: req_ready_o=0 in SCAN and RESP.
//  - rsp_way_o always exactly one-hot unless rsp_none_o; never selects a busy way.
//  - idx, cnt widths $clog2(WAYS)+1; wrap by mask of low bits (WAYS power of two).
//  - rst_ni asserted mid-SCAN/RESP: immediately IDLE, outputs to reset values, response lost.
//  - lfsr_shift_o at most one pulse per accepted request; never outside accept cycle.
// STRUCTURE
//  - Way-vector typedef (hpdcache_way_vector_t) and WAYS constant belong in hpdcache_pkg;
//    state enum stays local.
//  - One sub-module: hpdcache_prio_1hot_encoder (lowest-index one-hot pick for free ways).
//  - Elaboration assertions: WAYS power of two, LFSR_WIDTH >= $clog2(WAYS).
// TESTING
//  1 invalid-first: valid=8'b1111_0111, busy=0 -> rsp at T+1, way=8'b0000_1000, no LFSR pulse.
//  2 random hit: valid=8'hFF, busy=0, lfsr=8'hE5 -> start 5, lfsr_shift_o=1 at T, way=8'h20 T+1.
//  3 skip+wrap: valid=8'hFF, busy=8'b1110_0000, lfsr=8'h06 -> idx 6,7 busy, wraps,
//    way=8'h01, rsp_valid_o at T+3.
//  4 all locked: valid=8'hFF, busy=8'hFF -> rsp_none_o=1, way=0, rsp_valid_o at T+8.
//  5 backpressure: rsp_ready_i=0 for 5 cycles -> rsp stable, req_ready_o=0, second req held;
//    accepted cycle after handshake.
//  6 reset mid-SCAN (test 3 setup, rst_ni low at T+1) -> outputs zero, req_ready_o=1 after.

Source files
------------

// File: rtl/hpdcache_pkg.sv
// ---------------------------------------------------------------------------
// hpdcache_pkg
// Shared cache-geometry constants and types for the HPDcache slice.
//   HPDCACHE_WAYS          : default number of ways per set
//   hpdcache_way_vector_t  : one bit per way (valid, busy, one-hot selections)
// ---------------------------------------------------------------------------
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_WAYS = 8;

  typedef logic [HPDCACHE_WAYS-1:0] hpdcache_way_vector_t;

endpackage

// File: rtl/hpdcache_prio_1hot_encoder.sv
// ---------------------------------------------------------------------------
// hpdcache_prio_1hot_encoder
// Lowest-index priority pick: returns a one-hot vector with only the lowest
// set bit of the input kept (all-zero when the input is all-zero).
//   vec     in   N   candidate bits
//   onehot  out  N   lowest set bit of vec, one-hot
// ---------------------------------------------------------------------------
module hpdcache_prio_1hot_encoder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] onehot
);

  // Two's-complement trick: vec & -vec isolates the least-significant set bit.
  assign onehot = vec & (~vec + N'(1'b1));

endmodule

// File: rtl/hpdcache_victim_sel.sv
// ---------------------------------------------------------------------------
// hpdcache_victim_sel
// Victim-way selector for the random replacement policy. Prefers the lowest
// invalid, unlocked way; otherwise starts at an LFSR-chosen way and walks
// forward (one way per cycle, wrapping) until an unlocked way is found.
// Reports "none" when every way is locked. Requests the LFSR to advance only
// when its value is actually consumed.
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_valid_i/ready_o   request handshake (ready only while idle)
//   req_valid_ways_i      per-way valid bits of the target set
//   req_busy_ways_i       per-way lock; locked ways are never chosen
//   lfsr_val_i            current LFSR value
//   lfsr_shift_o          one-cycle pulse in the accept cycle when LFSR used
//   rsp_valid_o/ready_i   response handshake
//   rsp_way_o             one-hot victim (zero when rsp_none_o)
//   rsp_none_o            every way locked
// ---------------------------------------------------------------------------
module hpdcache_victim_sel
  import hpdcache_pkg::*;
#(
  parameter int unsigned WAYS       = HPDCACHE_WAYS,
  parameter int unsigned LFSR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [WAYS-1:0]       req_valid_ways_i,
  input  logic [WAYS-1:0]       req_busy_ways_i,
  input  logic [LFSR_WIDTH-1:0] lfsr_val_i,
  output logic                  lfsr_shift_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WAYS-1:0]       rsp_way_o,
  output logic                  rsp_none_o
);

  localparam int unsigned IDXW = $clog2(WAYS);
  localparam int unsigned IW   = IDXW + 1;
  localparam logic [IW-1:0] IDX_MASK = IW'(WAYS - 1);
  localparam logic [IW-1:0] WAYS_C   = IW'(WAYS);

  if ((WAYS < 2) || (WAYS > 32) || ((WAYS & (WAYS - 1)) != 0)) begin : g_bad_ways
    $error("hpdcache_victim_sel: WAYS must be a power of two in 2..32");
  end
  if (LFSR_WIDTH < IDXW) begin : g_bad_lfsr
    $error("hpdcache_victim_sel: LFSR_WIDTH must be >= $clog2(WAYS)");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_r, state_s;
  logic [WAYS-1:0] busy_r, busy_s;
  logic [IW-1:0]   idx_r, idx_s;
  logic [IW-1:0]   cnt_r, cnt_s;
  logic [WAYS-1:0] way_r, way_s;
  logic            none_r, none_s;
  logic            shift_s;

  logic [WAYS-1:0] free_s;
  logic [WAYS-1:0] free_1hot_s;
  logic [IDXW-1:0] start_s;
  logic [IW-1:0]   start_next_s;
  logic [WAYS-1:0] start_1hot_s;
  logic [IDXW-1:0] idx_lo_s;
  logic [WAYS-1:0] idx_1hot_s;
  logic            unused_s;

  assign free_s       = ~req_valid_ways_i & ~req_busy_ways_i;
  assign start_s      = lfsr_val_i[IDXW-1:0];
  assign start_next_s = ({1'b0, start_s} + IW'(1'b1)) & IDX_MASK;
  assign start_1hot_s = WAYS'(1'b1) << start_s;
  // idx is kept masked to the low bits, so its MSB is always zero.
  assign idx_lo_s     = idx_r[IDXW-1:0];
  assign idx_1hot_s   = WAYS'(1'b1) << idx_lo_s;
  assign unused_s     = ^{lfsr_val_i, idx_r[IW-1]};

  hpdcache_prio_1hot_encoder #(
    .N (WAYS)
  ) u_free_enc (
    .vec    (free_s),
    .onehot (free_1hot_s)
  );

  // Next-state, datapath-update and LFSR-shift decode.
  always_comb begin
    state_s = state_r;
    busy_s  = busy_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    way_s   = way_r;
    none_s  = none_r;
    shift_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid_i) begin
          busy_s = req_busy_ways_i;
          none_s = 1'b0;
          if (free_s != '0) begin
            way_s   = free_1hot_s;
            state_s = ST_RESP;
          end else begin
            // Random value consumed: ask the LFSR to advance.
            shift_s = 1'b1;
            if (!req_busy_ways_i[start_s]) begin
              way_s   = start_1hot_s;
              state_s = ST_RESP;
            end else begin
              way_s   = '0;
              idx_s   = start_next_s;
              cnt_s   = IW'(1'b1);
              state_s = ST_SCAN;
            end
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!busy_r[idx_lo_s]) begin
          way_s   = idx_1hot_s;
          state_s = ST_RESP;
        end else if ((cnt_r + IW'(1'b1)) == WAYS_C) begin
          // This was the last unexamined way: everything is locked.
          way_s   = '0;
          none_s  = 1'b1;
          state_s = ST_RESP;
        end else begin
          idx_s = (idx_r + IW'(1'b1)) & IDX_MASK;
          cnt_s = cnt_r + IW'(1'b1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          way_s   = '0;
          none_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        way_s   = '0;
        none_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      busy_r  <= '0;
      idx_r   <= '0;
      cnt_r   <= '0;
      way_r   <= '0;
      none_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      way_r   <= way_s;
      none_r  <= none_s;
    end
  end

  assign req_ready_o  = (state_r == ST_IDLE);
  assign rsp_valid_o  = (state_r == ST_RESP);
  assign rsp_way_o    = way_r;
  assign rsp_none_o   = none_r;
  assign lfsr_shift_o = shift_s;

endmodule

// File: tb/tb_hpdcache_victim_sel.sv
// ---------------------------------------------------------------------------
// tb_hpdcache_victim_sel
// Directed bench for hpdcache_victim_sel with WAYS=8, LFSR_WIDTH=8.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on
// the rising edge. "Cycle T" is the cycle whose rising edge accepts a request.
// ---------------------------------------------------------------------------
module tb_hpdcache_victim_sel;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] valid_ways;
  logic [7:0] busy_ways;
  logic [7:0] lfsr_val;
  logic       lfsr_shift;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_way;
  logic       rsp_none;

  int pass_cnt  = 0;
  int total_cnt = 0;

  hpdcache_victim_sel #(
    .WAYS       (8),
    .LFSR_WIDTH (8)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_valid_ways_i (valid_ways),
    .req_busy_ways_i  (busy_ways),
    .lfsr_val_i       (lfsr_val),
    .lfsr_shift_o     (lfsr_shift),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .rsp_way_o        (rsp_way),
    .rsp_none_o       (rsp_none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present a request at the falling edge before cycle T; checks the accept-
  // cycle outputs, then returns at the falling edge of cycle T+1.
  task automatic issue(input string tag, input logic [7:0] v, input logic [7:0] b,
                       input logic [7:0] l, input logic exp_shift);
    valid_ways = v;
    busy_ways  = b;
    lfsr_val   = l;
    req_valid  = 1'b1;
    #1;
    chk({tag, ".ready_at_T"}, 32'(req_ready), 32'd1);
    chk({tag, ".shift_at_T"}, 32'(lfsr_shift), 32'(exp_shift));
    @(negedge clk);
    req_valid  = 1'b0;
    valid_ways = 8'h00;
    busy_ways  = 8'h00;
    lfsr_val   = 8'h00;
    #1;
  endtask

  // Wait (bounded) for rsp_valid and check accept->valid latency and payload.
  task automatic wait_rsp(input string tag, input int exp_lat,
                          input logic [7:0] exp_way, input logic exp_none);
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      chk({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ".busy_shift"}, 32'(lfsr_shift), 32'd0);
      @(negedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".way"}, 32'(rsp_way), 32'(exp_way));
    chk({tag, ".none"}, 32'(rsp_none), 32'(exp_none));
    chk({tag, ".ready_in_resp"}, 32'(req_ready), 32'd0);
  endtask

  // Complete the response handshake and check the return to idle.
  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk({tag, ".valid_after_hs"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".ready_after_hs"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    valid_ways = 8'h00;
    busy_ways  = 8'h00;
    lfsr_val   = 8'h00;
    rsp_ready  = 1'b0;

    // Reset state
    #12;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_way", 32'(rsp_way), 32'd0);
    chk("rst.rsp_none", 32'(rsp_none), 32'd0);
    chk("rst.shift", 32'(lfsr_shift), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // 1: first invalid way wins, LFSR untouched
    issue("t1", 8'b1111_0111, 8'h00, 8'hE5, 1'b0);
    wait_rsp("t1", 1, 8'b0000_1000, 1'b0);
    finish_rsp("t1");

    // 2: all valid, start way 5 free
    issue("t2", 8'hFF, 8'h00, 8'hE5, 1'b1);
    wait_rsp("t2", 1, 8'h20, 1'b0);
    finish_rsp("t2");

    // 3: start 6, ways 6,7 locked, wrap to way 0
    issue("t3", 8'hFF, 8'b1110_0000, 8'h06, 1'b1);
    wait_rsp("t3", 3, 8'h01, 1'b0);
    finish_rsp("t3");

    // 4: every way locked
    issue("t4", 8'hFF, 8'hFF, 8'h03, 1'b1);
    wait_rsp("t4", 8, 8'h00, 1'b1);
    finish_rsp("t4");

    // Invalid way also locked is skipped in favour of next free invalid way
    issue("t4b", 8'b0011_1111, 8'b0100_0000, 8'h00, 1'b0);
    wait_rsp("t4b", 1, 8'h80, 1'b0);
    finish_rsp("t4b");

    // 5: backpressure with a second request held off
    issue("t5", 8'hFF, 8'h00, 8'h03, 1'b1);
    wait_rsp("t5", 1, 8'h08, 1'b0);
    valid_ways = 8'hFE;
    busy_ways  = 8'h00;
    lfsr_val   = 8'h07;
    req_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("t5.hold_valid", 32'(rsp_valid), 32'd1);
      chk("t5.hold_way", 32'(rsp_way), 32'h08);
      chk("t5.hold_ready", 32'(req_ready), 32'd0);
      chk("t5.hold_shift", 32'(lfsr_shift), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("t5.after_hs_valid", 32'(rsp_valid), 32'd0);
    chk("t5.after_hs_ready", 32'(req_ready), 32'd1);
    chk("t5.after_hs_shift", 32'(lfsr_shift), 32'd0);
    @(negedge clk);
    req_valid  = 1'b0;
    valid_ways = 8'h00;
    #1;
    chk("t5.second_valid", 32'(rsp_valid), 32'd1);
    chk("t5.second_way", 32'(rsp_way), 32'h01);
    finish_rsp("t5b");

    // 6: reset while scanning
    issue("t6", 8'hFF, 8'b1110_0000, 8'h06, 1'b1);
    chk("t6.in_scan_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6.rst_valid", 32'(rsp_valid), 32'd0);
    chk("t6.rst_way", 32'(rsp_way), 32'd0);
    chk("t6.rst_none", 32'(rsp_none), 32'd0);
    chk("t6.rst_shift", 32'(lfsr_shift), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6.ready_after", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("t6.no_stale_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    issue("t6r", 8'b1111_1101, 8'h00, 8'h00, 1'b0);
    wait_rsp("t6r", 1, 8'h02, 1'b0);
    finish_rsp("t6r");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
